// File: rtl/systolic_pkg.sv
// Shared widths, lane slicing helper and accumulator type for the systolic matrix-multiply engine.
package systolic_pkg;

    localparam int ARRAYWIDTH_DEF          = 4;
    localparam int ARRAYHEIGHT_DEF         = 4;
    localparam int DATASIZE_DEF            = 8;
    localparam int OUTPUT_BUF_DATASIZE_DEF = 32;
    localparam int DSP_DELAY_DEF           = 1;

    typedef logic [OUTPUT_BUF_DATASIZE_DEF-1:0] psum_t;

    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/systolic_pe.sv
// One weight-stationary MAC cell: holds a weight, forwards activation/valid right, accumulates psum downward.
// SIGNED_ARITH_EN selects two's complement operands; default is unsigned.
module systolic_pe
    import systolic_pkg::*;
#(
    parameter int DATASIZE            = DATASIZE_DEF,
    parameter int OUTPUT_BUF_DATASIZE = OUTPUT_BUF_DATASIZE_DEF,
    parameter int DSP_DELAY           = DSP_DELAY_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           w_shift,
    input  logic [DATASIZE-1:0]            w_in,
    output logic [DATASIZE-1:0]            w_out,
    input  logic [DATASIZE-1:0]            act_in,
    input  logic                           act_vld_in,
    output logic [DATASIZE-1:0]            act_out,
    output logic                           act_vld_out,
    input  logic [OUTPUT_BUF_DATASIZE-1:0] psum_in,
    output logic [OUTPUT_BUF_DATASIZE-1:0] psum_out
);

    localparam int PROD_W = 2 * DATASIZE;

    logic [DATASIZE-1:0]            weight;
    logic [DATASIZE-1:0]            act_p  [DSP_DELAY];
    logic                           vld_p  [DSP_DELAY];
    logic [OUTPUT_BUF_DATASIZE-1:0] psum_p [DSP_DELAY];

    function automatic logic [OUTPUT_BUF_DATASIZE-1:0] mac_term(
        input logic [DATASIZE-1:0] a,
        input logic [DATASIZE-1:0] w
    );
`ifdef SIGNED_ARITH_EN
        logic signed [PROD_W-1:0] prod;
        prod = PROD_W'($signed(a)) * PROD_W'($signed(w));
`else
        logic [PROD_W-1:0] prod;
        prod = PROD_W'(a) * PROD_W'(w);
`endif
        return OUTPUT_BUF_DATASIZE'(prod);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            weight <= '0;
        end else if (w_shift) begin
            weight <= w_in;
        end
    end

    // stage p0: multiply-accumulate; later stages only add latency so act and psum stay aligned
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < DSP_DELAY; s++) begin
                act_p[s]  <= '0;
                vld_p[s]  <= 1'b0;
                psum_p[s] <= '0;
            end
        end else begin
            act_p[0]  <= act_in;
            vld_p[0]  <= act_vld_in;
            psum_p[0] <= psum_in + mac_term(act_in, weight);
            for (int s = 1; s < DSP_DELAY; s++) begin
                act_p[s]  <= act_p[s-1];
                vld_p[s]  <= vld_p[s-1];
                psum_p[s] <= psum_p[s-1];
            end
        end
    end

    assign w_out       = weight;
    assign act_out     = act_p[DSP_DELAY-1];
    assign act_vld_out = vld_p[DSP_DELAY-1];
    assign psum_out    = psum_p[DSP_DELAY-1];

endmodule

// File: rtl/systolic_array_top.sv
// Weight-stationary N x N systolic matrix multiply (R = A x W) with input, weight and output row buffers.
// Define SIGNED_ARITH_EN for two's complement activations/weights; default build is unsigned.
module systolic_array_top
    import systolic_pkg::*;
#(
    parameter int ARRAYWIDTH          = ARRAYWIDTH_DEF,
    parameter int ARRAYHEIGHT         = ARRAYHEIGHT_DEF,
    parameter int DATASIZE            = DATASIZE_DEF,
    parameter int OUTPUT_BUF_DATASIZE = OUTPUT_BUF_DATASIZE_DEF,
    parameter int DSP_DELAY           = DSP_DELAY_DEF
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      input_buffer_load_en,
    input  logic                                      input_buffer_out_en,
    input  logic                                      weight_buffer_load_en,
    input  logic                                      weight_buffer_out_en,
    input  logic                                      write_weight_en,
    input  logic                                      output_buffer_load_en,
    input  logic                                      output_buffer_out_en,
    input  logic [DATASIZE*ARRAYWIDTH-1:0]            in_act,
    input  logic [DATASIZE*ARRAYWIDTH-1:0]            in_weight,
    output logic [OUTPUT_BUF_DATASIZE*ARRAYWIDTH-1:0] out_res
);

    localparam int NH    = ARRAYHEIGHT;
    localparam int NW    = ARRAYWIDTH;
    localparam int OW    = OUTPUT_BUF_DATASIZE;
    localparam int ROW_W = DATASIZE * NW;
    localparam int PTR_W = (NH > 1) ? $clog2(NH) : 1;
    localparam int CNT_W = $clog2(NH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NH - 1);
    localparam logic [CNT_W-1:0] DEPTH    = CNT_W'(NH);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // Input row FIFO
    logic [ROW_W-1:0] in_mem [NH];
    logic [PTR_W-1:0] in_wp, in_rp;
    logic [CNT_W-1:0] in_cnt;
    logic             in_pop, in_push;
    logic [ROW_W-1:0] in_row;

    assign in_pop  = input_buffer_out_en && (in_cnt != '0);
    assign in_push = input_buffer_load_en && ((in_cnt != DEPTH) || in_pop);
    assign in_row  = in_pop ? in_mem[in_rp] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_wp  <= '0;
            in_rp  <= '0;
            in_cnt <= '0;
        end else begin
            if (in_push) in_wp <= ptr_inc(in_wp);
            if (in_pop)  in_rp <= ptr_inc(in_rp);
            if (in_push && !in_pop)      in_cnt <= in_cnt + CNT_W'(1);
            else if (in_pop && !in_push) in_cnt <= in_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (in_push) in_mem[in_wp] <= in_act;
    end

    // Weight row FIFO
    logic [ROW_W-1:0] w_mem [NH];
    logic [PTR_W-1:0] w_wp, w_rp;
    logic [CNT_W-1:0] w_cnt;
    logic             w_pop, w_push, w_shift;
    logic [ROW_W-1:0] w_row;

    assign w_pop   = weight_buffer_out_en && (w_cnt != '0);
    assign w_push  = weight_buffer_load_en && ((w_cnt != DEPTH) || w_pop);
    assign w_row   = w_pop ? w_mem[w_rp] : '0;
    assign w_shift = write_weight_en && weight_buffer_out_en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_wp  <= '0;
            w_rp  <= '0;
            w_cnt <= '0;
        end else begin
            if (w_push) w_wp <= ptr_inc(w_wp);
            if (w_pop)  w_rp <= ptr_inc(w_rp);
            if (w_push && !w_pop)      w_cnt <= w_cnt + CNT_W'(1);
            else if (w_pop && !w_push) w_cnt <= w_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) w_mem[w_wp] <= in_weight;
    end

    logic [DATASIZE-1:0] act_h  [NH][NW+1];
    logic                vld_h  [NH][NW+1];
    logic [OW-1:0]       psum_v [NH+1][NW];
    logic [DATASIZE-1:0] w_reg  [NH][NW];

    // Lane k enters PE row k k*DSP_DELAY cycles late so it meets the psum coming down from row k-1
    for (genvar k = 0; k < NH; k++) begin : g_skew
        logic [DATASIZE-1:0] lane_act;
        assign lane_act = in_row[lane_lsb(k, DATASIZE) +: DATASIZE];
        if (k == 0) begin : g_direct
            assign act_h[k][0] = lane_act;
            assign vld_h[k][0] = in_pop;
        end else begin : g_delay
            localparam int SK = k * DSP_DELAY;
            logic [DATASIZE-1:0] sk_act_p [SK];
            logic                sk_vld_p [SK];
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int s = 0; s < SK; s++) begin
                        sk_act_p[s] <= '0;
                        sk_vld_p[s] <= 1'b0;
                    end
                end else begin
                    sk_act_p[0] <= lane_act;
                    sk_vld_p[0] <= in_pop;
                    for (int s = 1; s < SK; s++) begin
                        sk_act_p[s] <= sk_act_p[s-1];
                        sk_vld_p[s] <= sk_vld_p[s-1];
                    end
                end
            end
            assign act_h[k][0] = sk_act_p[SK-1];
            assign vld_h[k][0] = sk_vld_p[SK-1];
        end
    end

    // Weights enter at the bottom row and shift upward, so the k-th row pushed ends in PE row k
    for (genvar k = 0; k < NH; k++) begin : g_row
        logic unused_tail;
        assign unused_tail = ^{act_h[k][NW], vld_h[k][NW], w_reg[0][k]};
        for (genvar j = 0; j < NW; j++) begin : g_col
            logic [DATASIZE-1:0] w_src;
            if (k == NH - 1) begin : g_wload
                assign w_src = w_row[lane_lsb(j, DATASIZE) +: DATASIZE];
            end else begin : g_wchain
                assign w_src = w_reg[k+1][j];
            end
            systolic_pe #(
                .DATASIZE            (DATASIZE),
                .OUTPUT_BUF_DATASIZE (OW),
                .DSP_DELAY           (DSP_DELAY)
            ) u_pe (
                .clk         (clk),
                .rst         (rst),
                .w_shift     (w_shift),
                .w_in        (w_src),
                .w_out       (w_reg[k][j]),
                .act_in      (act_h[k][j]),
                .act_vld_in  (vld_h[k][j]),
                .act_out     (act_h[k][j+1]),
                .act_vld_out (vld_h[k][j+1]),
                .psum_in     (psum_v[k][j]),
                .psum_out    (psum_v[k+1][j])
            );
        end
    end

    // Output buffer: per-column write pointers absorb the column skew, no explicit deskew needed
    logic [OW-1:0]    out_mem [NH][NW];
    logic [PTR_W-1:0] out_wp  [NW];
    logic [PTR_W-1:0] out_rp;
    logic [NH-1:0]    row_full;
    logic [NW-1:0]    res_vld;

    for (genvar j = 0; j < NW; j++) begin : g_cap
        assign psum_v[0][j] = '0;
        assign res_vld[j]   = output_buffer_load_en && vld_h[NH-1][j+1];
    end

    always_ff @(posedge clk) begin
        for (int j = 0; j < NW; j++) begin
            if (res_vld[j]) out_mem[out_wp[j]][j] <= psum_v[NH][j];
        end
    end

    // The last column completes a row, so it marks the row readable
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int j = 0; j < NW; j++) out_wp[j] <= '0;
            out_rp   <= '0;
            row_full <= '0;
        end else begin
            for (int j = 0; j < NW; j++) begin
                if (res_vld[j]) out_wp[j] <= ptr_inc(out_wp[j]);
            end
            if (output_buffer_out_en) begin
                out_rp           <= ptr_inc(out_rp);
                row_full[out_rp] <= 1'b0;
            end
            if (res_vld[NW-1]) row_full[out_wp[NW-1]] <= 1'b1;
        end
    end

    always_comb begin
        out_res = '0;
        if (output_buffer_out_en && row_full[out_rp]) begin
            for (int j = 0; j < NW; j++) out_res[lane_lsb(j, OW) +: OW] = out_mem[out_rp][j];
        end
    end

endmodule

// File: tb/tb_systolic_array_top.sv
// Scoreboard bench for systolic_array_top: reads queue expected rows, a negedge monitor compares them.
module tb_systolic_array_top;
    import systolic_pkg::*;

    localparam int N  = 4;
    localparam int DS = 8;
    localparam int OW = 32;

    typedef logic [N*OW-1:0] row_t;

    logic clk = 1'b0;
    logic rst;
    logic input_buffer_load_en, input_buffer_out_en;
    logic weight_buffer_load_en, weight_buffer_out_en, write_weight_en;
    logic output_buffer_load_en, output_buffer_out_en;
    logic [DS*N-1:0] in_act, in_weight;
    logic [OW*N-1:0] out_res;

    int checks = 0;
    int errors = 0;

    row_t  exp_q [$];
    string tag_q [$];
    row_t  mon_exp;
    string mon_tag;

    logic [DS-1:0] A [N][N];
    logic [DS-1:0] W [N][N];
    row_t exp_rows [N];

    always #5 clk = ~clk;

    systolic_array_top dut (
        .clk                   (clk),
        .rst                   (rst),
        .input_buffer_load_en  (input_buffer_load_en),
        .input_buffer_out_en   (input_buffer_out_en),
        .weight_buffer_load_en (weight_buffer_load_en),
        .weight_buffer_out_en  (weight_buffer_out_en),
        .write_weight_en       (write_weight_en),
        .output_buffer_load_en (output_buffer_load_en),
        .output_buffer_out_en  (output_buffer_out_en),
        .in_act                (in_act),
        .in_weight             (in_weight),
        .out_res               (out_res)
    );

    always @(negedge clk) begin
        checks++;
        if (output_buffer_out_en) begin
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL extra_read: got %h, required no read pending", out_res);
            end else begin
                mon_exp = exp_q.pop_front();
                mon_tag = tag_q.pop_front();
                if (out_res !== mon_exp) begin
                    errors++;
                    $display("FAIL %s: got %h, required %h", mon_tag, out_res, mon_exp);
                end
            end
        end else if (out_res !== '0) begin
            errors++;
            $display("FAIL idle_zero: got %h, required 0", out_res);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_weights();
        for (int k = 0; k < N; k++) begin
            for (int l = 0; l < N; l++) in_weight[l*DS +: DS] = W[k][l];
            weight_buffer_load_en = 1'b1;
            tick();
        end
        weight_buffer_load_en = 1'b0;
        weight_buffer_out_en  = 1'b1;
        write_weight_en       = 1'b1;
        repeat (N) tick();
        weight_buffer_out_en  = 1'b0;
        write_weight_en       = 1'b0;
    endtask

    // Push N rows of A (plus an optional extra row that a full FIFO must drop), stream, then drain.
    task automatic compute(input bit push_extra);
        for (int i = 0; i < N; i++) begin
            for (int l = 0; l < N; l++) in_act[l*DS +: DS] = A[i][l];
            input_buffer_load_en = 1'b1;
            tick();
        end
        if (push_extra) begin
            in_act = 32'h7F7F_7F7F;
            tick();
        end
        input_buffer_load_en = 1'b0;
        input_buffer_out_en  = 1'b1;
        repeat (N + 1) tick();
        input_buffer_out_en  = 1'b0;
        repeat (20) tick();
    endtask

    task automatic read_rows(input string tag, input bit zeros);
        for (int r = 0; r < N; r++) begin
            exp_q.push_back(zeros ? row_t'(0) : exp_rows[r]);
            tag_q.push_back($sformatf("%s_row%0d", tag, r));
            output_buffer_out_en = 1'b1;
            tick();
        end
        output_buffer_out_en = 1'b0;
    endtask

    task automatic model_rows();
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                psum_t acc;
                acc = '0;
                for (int k = 0; k < N; k++) acc += psum_t'(A[i][k]) * psum_t'(W[k][j]);
                exp_rows[i][j*OW +: OW] = acc;
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        {input_buffer_load_en, input_buffer_out_en, weight_buffer_load_en} = '0;
        {weight_buffer_out_en, write_weight_en, output_buffer_out_en} = '0;
        output_buffer_load_en = 1'b0;
        in_act = '0;
        in_weight = '0;
        tick();
        // out_res held at zero in reset even with a read requested
        read_rows("reset_state", 1'b1);
        rst = 1'b1;
        output_buffer_load_en = 1'b1;
        tick();

        // all ones -> every lane 4
        for (int a = 0; a < N; a++) for (int b = 0; b < N; b++) begin A[a][b] = 8'd1; W[a][b] = 8'd1; end
        load_weights();
        compute(1'b0);
        for (int i = 0; i < N; i++) exp_rows[i] = {N{32'd4}};
        read_rows("all_ones", 1'b0);

        // max values -> 4*0xFE01, or 4 for signed -1*-1
        for (int a = 0; a < N; a++) for (int b = 0; b < N; b++) begin A[a][b] = 8'hFF; W[a][b] = 8'hFF; end
        load_weights();
        compute(1'b0);
`ifdef SIGNED_ARITH_EN
        for (int i = 0; i < N; i++) exp_rows[i] = {N{32'd4}};
`else
        for (int i = 0; i < N; i++) exp_rows[i] = {N{32'h0003_F804}};
`endif
        read_rows("max_vals", 1'b0);
        // exactly N rows were stored; further reads return zeros
        read_rows("drained", 1'b1);

        // identity weights -> rows equal A rows zero-extended
        for (int a = 0; a < N; a++) for (int b = 0; b < N; b++) begin
            W[a][b] = (a == b) ? 8'd1 : 8'd0;
            A[a][b] = 8'(4*a + b + 1);
        end
        load_weights();
        compute(1'b0);
        exp_rows[0] = {32'd4, 32'd3, 32'd2, 32'd1};
        exp_rows[1] = {32'd8, 32'd7, 32'd6, 32'd5};
        exp_rows[2] = {32'd12, 32'd11, 32'd10, 32'd9};
        exp_rows[3] = {32'd16, 32'd15, 32'd14, 32'd13};
        read_rows("identity", 1'b0);

        // back-to-back batch, same weights, with a push into a full input FIFO
        for (int a = 0; a < N; a++) for (int b = 0; b < N; b++) A[a][b] = 8'(16*b + a + 3);
        compute(1'b1);
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) exp_rows[i][j*OW +: OW] = 32'(16*j + i + 3);
        read_rows("back_to_back", 1'b0);

        // reset mid-compute
        for (int a = 0; a < N; a++) for (int b = 0; b < N; b++) begin
            W[a][b] = 8'(a + 2*b + 1);
            A[a][b] = 8'(3*a + b + 2);
        end
        load_weights();
        for (int i = 0; i < N; i++) begin
            for (int l = 0; l < N; l++) in_act[l*DS +: DS] = A[i][l];
            input_buffer_load_en = 1'b1;
            tick();
        end
        input_buffer_load_en = 1'b0;
        input_buffer_out_en  = 1'b1;
        repeat (2) tick();
        input_buffer_out_en  = 1'b0;
        rst = 1'b0;
        #1;
        exp_q.push_back(row_t'(0));
        tag_q.push_back("reset_mid_out");
        output_buffer_out_en = 1'b1;
        tick();
        output_buffer_out_en = 1'b0;
        rst = 1'b1;
        tick();
        // input buffer must be empty: popping injects nothing valid
        load_weights();
        input_buffer_out_en = 1'b1;
        repeat (N) tick();
        input_buffer_out_en = 1'b0;
        repeat (20) tick();
        read_rows("after_reset_empty", 1'b1);
        // full rerun after reset
        load_weights();
        compute(1'b0);
        model_rows();
        read_rows("rerun", 1'b0);

        repeat (3) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_reads: got %0d outstanding, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
